instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks the PC, issues word-aligned reads to instruction
// memory, delivers the fetched word with a one-cycle IR_write strobe, and flags read timeouts.
module instruction_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic        IR_write,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DELIVER = 2'd2,
    ERROR   = 2'd3
  } state_t;

  localparam logic [7:0]  TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic        mem_rd_q, mem_rd_d;
  logic        ir_write_q, ir_write_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    wait_d     = wait_q;
    mem_rd_d   = mem_rd_q;
    ir_write_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        // A PC load wins over a fetch request in the same cycle.
        if (pc_load) begin
          pc_d = pc_in & ALIGN_MASK;
        end else if (fetch_req) begin
          state_d    = READ;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_q & ALIGN_MASK;
          wait_d     = 8'd0;
        end
      end
      READ: begin
        if (mem_ack) begin
          instr_d    = mem_rdata;
          mem_rd_d   = 1'b0;
          ir_write_d = 1'b1;
          state_d    = DELIVER;
        end else begin
          wait_d = 8'(wait_q + 8'd1);
          if (wait_d == TIMEOUT_C) begin
            mem_rd_d = 1'b0;
            err_d    = 1'b1;
            state_d  = ERROR;
          end
        end
      end
      DELIVER: begin
        pc_d    = pc_load ? (pc_in & ALIGN_MASK) : 32'(pc_q + 32'd4);
        state_d = IDLE;
      end
      ERROR: begin
        // Recovery needs an explicit redirect so the failed address is not retried blindly.
        if (fetch_req && pc_load) begin
          pc_d    = pc_in & ALIGN_MASK;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      mem_addr_q <= 32'd0;
      instr_q    <= 32'd0;
      wait_q     <= 8'd0;
      mem_rd_q   <= 1'b0;
      ir_write_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      wait_q     <= wait_d;
      mem_rd_q   <= mem_rd_d;
      ir_write_q <= ir_write_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign instr_out = instr_q;
  assign IR_write  = ir_write_q;
  assign pc_out    = pc_q;
  assign busy      = busy_q;
  assign fetch_err = err_q;
  assign dbg_state = state_q;

endmodule
